// File: rtl/mouse_joy_emu.sv
// mouse_joy_emu
// Mouse-to-analog-joystick emulator in the clk_sys domain. It integrates PS/2
// mouse deltas from hps_io into saturating signed axis positions. It selects
// the mouse path automatically whenever mouse packets arrive. The selection
// falls back to the real joystick on clear, joystick activity or when mouse
// emulation is disabled.
//
// Optional feature: define MOUSE_JOY_RECENTER_EN to recentre the axes after a
// period of mouse inactivity (adds parameters RECENTER_IDLE / RECENTER_DIV).
//
// Ports:
//   clk_sys        system clock
//   reset_n        asynchronous active-low reset
//   ps2_mouse      hps_io mouse word: [24] toggle strobe, [23:16] dy,
//                  [15:8] dx, [5] y sign, [4] x sign, [1:0] L/R buttons
//   joy_x, joy_y   signed analog joystick axes
//   joy_fire       joystick fire button
//   joy_active     any digital joystick bit set
//   mouse_disable  mouse emulation off (OSD option); "disable" is a reserved
//                  word in SystemVerilog, hence the longer name
//   clear          synchronous clear (e.g. core reset request)
//   out_x, out_y   signed AW-bit axes to the core
//   out_fire       fire to the core
//   mouse_sel      1 = outputs driven from the mouse
module mouse_joy_emu #(
    parameter int AW       = 8,
    parameter int SHIFT    = 1,
    parameter int STEP_MAX = 10
`ifdef MOUSE_JOY_RECENTER_EN
   ,parameter int RECENTER_IDLE = 2000000,
    parameter int RECENTER_DIV  = 4096
`endif
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [24:0]   ps2_mouse,
    input  logic [7:0]    joy_x,
    input  logic [7:0]    joy_y,
    input  logic          joy_fire,
    input  logic          joy_active,
    input  logic          mouse_disable,
    input  logic          clear,
    output logic [AW-1:0] out_x,
    output logic [AW-1:0] out_y,
    output logic          out_fire,
    output logic          mouse_sel
);

    localparam logic [1:0] ST_JOY   = 2'd0;
    localparam logic [1:0] ST_MOUSE = 2'd1;
`ifdef MOUSE_JOY_RECENTER_EN
    localparam logic [1:0] ST_IDLE  = 2'd2;
`endif

    localparam logic signed [9:0]    SMAX = 10'(STEP_MAX);
    localparam logic signed [AW+1:0] PMAX = (AW+2)'((2 ** (AW - 1)) - 1);
    localparam logic signed [AW+1:0] PMIN = (AW+2)'(-(2 ** (AW - 1)));

    logic [1:0]           state, state_nx;
    logic                 primed;
    logic                 stb_q;
    logic                 stb_edge;
    logic                 force_joy;
    logic                 pend;
    logic signed [9:0]    step_x, step_y;
    logic signed [AW-1:0] pos_x, pos_y, x_nx, y_nx;
    logic                 sel_nx;
    logic                 unused_bits;

    assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

    // 9-bit signed delta, sensitivity shift, then per-packet clamp.
    function automatic logic signed [9:0] mk_step(input logic sgn, input logic [7:0] d);
        logic signed [9:0] v;
        v = $signed({sgn, sgn, d}) >>> SHIFT;
        if (v > SMAX)
            v = SMAX;
        else if (v < -SMAX)
            v = -SMAX;
        return v;
    endfunction

    // Sum in AW+2 bits so the saturation test cannot itself overflow.
    function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] p,
                                                      input logic signed [9:0]    s);
        logic signed [AW+1:0] sum;
        sum = (AW+2)'(p) + (AW+2)'(s);
        if (sum > PMAX)
            sum = PMAX;
        else if (sum < PMIN)
            sum = PMIN;
        return sum[AW-1:0];
    endfunction

`ifdef MOUSE_JOY_RECENTER_EN
    localparam int IW = $clog2(RECENTER_IDLE + 1);
    localparam int DW = $clog2(RECENTER_DIV + 1);

    logic [IW-1:0] idle_cnt;
    logic [DW-1:0] div_cnt;
    logic          idle_done;
    logic          div_tick;

    assign idle_done = (idle_cnt == IW'(RECENTER_IDLE - 1));
    assign div_tick  = (div_cnt == DW'(RECENTER_DIV - 1));

    function automatic logic [AW-1:0] toward_zero(input logic [AW-1:0] p);
        if (p == '0)
            return p;
        else if (p[AW-1])
            return p + AW'(1);
        else
            return p - AW'(1);
    endfunction
`endif

    assign force_joy = clear | joy_active | mouse_disable;
    // No edge on the priming cycle: stb_q still holds its reset value then.
    assign stb_edge  = primed & (ps2_mouse[24] != stb_q);
    assign mouse_sel = (state != ST_JOY);
    assign sel_nx    = (state_nx != ST_JOY);

    // Deltas are registered on the edge cycle and applied one cycle later;
    // a force on either cycle wins over the pending update.
    always_comb begin
        state_nx = state;
        x_nx     = pos_x;
        y_nx     = pos_y;
        if (force_joy) begin
            state_nx = ST_JOY;
            x_nx     = '0;
            y_nx     = '0;
        end else if (pend) begin
            state_nx = ST_MOUSE;
            x_nx     = sat_add(pos_x, step_x);
            y_nx     = sat_add(pos_y, -step_y);
        end
`ifdef MOUSE_JOY_RECENTER_EN
        else if (state == ST_MOUSE && idle_done) begin
            state_nx = ST_IDLE;
        end else if (state == ST_IDLE && div_tick) begin
            x_nx = toward_zero(pos_x);
            y_nx = toward_zero(pos_y);
        end
`endif
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_JOY;
            primed   <= 1'b0;
            stb_q    <= 1'b0;
            pend     <= 1'b0;
            step_x   <= '0;
            step_y   <= '0;
            pos_x    <= '0;
            pos_y    <= '0;
            out_x    <= '0;
            out_y    <= '0;
            out_fire <= 1'b0;
        end else begin
            primed   <= 1'b1;
            stb_q    <= ps2_mouse[24];
            pend     <= stb_edge & ~force_joy;
            step_x   <= mk_step(ps2_mouse[4], ps2_mouse[15:8]);
            step_y   <= mk_step(ps2_mouse[5], ps2_mouse[23:16]);
            state    <= state_nx;
            pos_x    <= x_nx;
            pos_y    <= y_nx;
            // Output select follows the next state so a forced switch to the
            // joystick shows up on the very next cycle.
            out_x    <= sel_nx ? pos_x : AW'(joy_x) << (AW - 8);
            out_y    <= sel_nx ? pos_y : AW'(joy_y) << (AW - 8);
            out_fire <= sel_nx ? |ps2_mouse[1:0] : joy_fire;
        end
    end

`ifdef MOUSE_JOY_RECENTER_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
            div_cnt  <= '0;
        end else begin
            if (force_joy || pend || state != ST_MOUSE)
                idle_cnt <= '0;
            else if (!idle_done)
                idle_cnt <= idle_cnt + 1'b1;

            if (state == ST_IDLE && !force_joy && !pend)
                div_cnt <= div_tick ? '0 : div_cnt + 1'b1;
            else
                div_cnt <= '0;
        end
    end
`endif

endmodule
